// File: rtl/fir_mac_scheduler_pkg.sv
// rtl/fir_mac_scheduler_pkg.sv - shared types, defaults and saturation helper for the FIR MAC scheduler
package FIR_types;

  localparam int NTAPS_DEFAULT = 4;
  localparam int FRAC_DEFAULT  = 15;

  typedef logic signed [15:0] array_of_4_signed_16 [NTAPS_DEFAULT];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DONE
  } fir_state_e;

  // Clamp a wide signed value into the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -64'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/fir_mac_scheduler_window.sv
// rtl/fir_mac_scheduler_window.sv - NTAPS-deep sample window, newest sample at index 0
module fir_tap_window
  import FIR_types::*;
#(
  parameter int NTAPS = NTAPS_DEFAULT,
  parameter int KW    = $clog2(NTAPS_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_shift,
  input  logic signed [15:0] i_sample,
  input  logic [KW-1:0]      i_rd_idx,
  output logic signed [15:0] o_rd_data
);

  logic signed [15:0] r_win [NTAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NTAPS; j++) begin
        r_win[j] <= '0;
      end
    end else if (i_shift) begin
      r_win[0] <= i_sample;
      for (int j = 1; j < NTAPS; j++) begin
        r_win[j] <= r_win[j-1];
      end
    end
  end

  assign o_rd_data = r_win[i_rd_idx];

endmodule

// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - time-multiplexed FIR controller sharing one MAC across all taps
module fir_mac_scheduler
  import FIR_types::*;
#(
  parameter int NTAPS = NTAPS_DEFAULT,
  parameter int FRAC  = FRAC_DEFAULT
) (
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [15:0]       in_sample,
  input  logic                     coef_we,
  output logic                     coef_ready,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic signed [15:0]       coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [15:0]       out_sample,
  output logic                     busy
);

  localparam int KW   = $clog2(NTAPS);
  localparam int ACCW = 32 + KW;

  fir_state_e r_state;
  fir_state_e w_state_nxt;

  logic signed [ACCW-1:0] r_acc;
  logic [KW-1:0]          r_k;
  logic signed [15:0]     r_out;
  logic signed [15:0]     r_coef [NTAPS];

  logic                   w_accept;
  logic                   w_last;
  logic signed [15:0]     w_win_k;
  logic signed [15:0]     w_coef_k;
  logic signed [31:0]     w_prod;
  logic signed [ACCW-1:0] w_acc_next;
  logic signed [63:0]     w_shifted;

  fir_tap_window #(
    .NTAPS (NTAPS),
    .KW    (KW)
  ) u_window (
    .clk       (system1000),
    .rst       (system1000_rst),
    .i_shift   (w_accept),
    .i_sample  (in_sample),
    .i_rd_idx  (r_k),
    .o_rd_data (w_win_k)
  );

  assign w_coef_k   = r_coef[r_k];
  assign w_prod     = 32'(w_win_k) * 32'(w_coef_k);
  assign w_acc_next = r_acc + ACCW'(w_prod);
  assign w_shifted  = 64'(w_acc_next) >>> FRAC;
  assign out_sample = r_out;

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    coef_ready  = 1'b1;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_MAC;
        end
      end
      ST_MAC: begin
        coef_ready = 1'b0;
        busy       = 1'b1;
        if (r_k == KW'(NTAPS - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The result is captured from the final accumulation so it is stable for all of DONE.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_acc <= '0;
      r_k   <= '0;
      r_out <= '0;
      for (int j = 0; j < NTAPS; j++) begin
        r_coef[j] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_acc <= '0;
        r_k   <= '0;
      end else if (r_state == ST_MAC) begin
        r_acc <= w_acc_next;
        r_k   <= w_last ? '0 : r_k + 1'b1;
        if (w_last) begin
          r_out <= sat16(w_shifted);
        end
      end
      if (coef_we && coef_ready && (int'(coef_addr) < NTAPS)) begin
        r_coef[coef_addr] <= coef_data;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb/tb_fir_mac_scheduler.sv - self-checking bench for fir_mac_scheduler against an arithmetic reference model
module tb_fir_mac_scheduler;
  import FIR_types::*;

  localparam int NT = NTAPS_DEFAULT;
  localparam int FR = FRAC_DEFAULT;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [15:0]    in_sample;
  logic                  coef_we;
  logic                  coef_ready;
  logic [$clog2(NT)-1:0] coef_addr;
  logic signed [15:0]    coef_data;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [15:0]    out_sample;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  array_of_4_signed_16 m_win;
  array_of_4_signed_16 m_coef;

  always #5 clk = ~clk;

  fir_mac_scheduler #(
    .NTAPS (NT),
    .FRAC  (FR)
  ) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sample      (in_sample),
    .coef_we        (coef_we),
    .coef_ready     (coef_ready),
    .coef_addr      (coef_addr),
    .coef_data      (coef_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sample     (out_sample),
    .busy           (busy)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model_y();
    longint sum;
    longint s;
    sum = 0;
    for (int j = 0; j < NT; j++) begin
      sum += longint'(m_win[j]) * longint'(m_coef[j]);
    end
    s = sum >>> FR;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NT; j++) begin
      m_win[j]  = '0;
      m_coef[j] = '0;
    end
  endtask

  task automatic write_coef(input int addr, input logic signed [15:0] data);
    int cnt;
    coef_we   = 1'b1;
    coef_addr = addr[$clog2(NT)-1:0];
    coef_data = data;
    cnt = 0;
    while (!coef_ready && cnt < 20) begin
      step();
      cnt++;
    end
    chk("coef_wait_bound", longint'(cnt < 20), 1);
    step();
    coef_we = 1'b0;
    m_coef[addr] = data;
  endtask

  // Sends one sample, holds out_ready low for bp cycles of DONE while offering a rival sample.
  task automatic send(input string tag, input logic signed [15:0] s, input int bp);
    int     cnt;
    longint exp;
    chk({tag, "_in_ready"}, longint'(in_ready), 1);
    in_valid  = 1'b1;
    in_sample = s;
    out_ready = (bp == 0);
    step();
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    in_sample = 16'($urandom);
    for (int j = NT - 1; j > 0; j--) m_win[j] = m_win[j-1];
    m_win[0] = s;
    exp = model_y();
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      chk({tag, "_busy_mac"}, longint'(busy), 1);
      step();
      cnt++;
    end
    chk({tag, "_latency"}, cnt, NT);
    chk({tag, "_out"}, longint'(out_sample), exp);
    for (int c = 0; c < bp; c++) begin
      in_valid = 1'b1;
      step();
      chk({tag, "_hold_valid"}, longint'(out_valid), 1);
      chk({tag, "_hold_out"}, longint'(out_sample), exp);
      chk({tag, "_hold_in_ready"}, longint'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk({tag, "_valid_drop"}, longint'(out_valid), 0);
    chk({tag, "_idle_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    int     cnt;
    int     bad;
    int     a;
    longint exp;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sample = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_coef_ready", longint'(coef_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_out_sample", longint'(out_sample), 0);

    for (int j = 0; j < NT; j++) write_coef(j, 16'sh4000);
    send("gain", 16'sd1000, 0);

    model_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    write_coef(0, 16'sh1000);
    write_coef(1, 16'sh2000);
    write_coef(2, 16'sh3000);
    write_coef(3, 16'sh4000);
    send("imp0", 16'sd32767, 0);
    send("imp1", 16'sd0, 0);
    send("imp2", 16'sd0, 0);
    send("imp3", 16'sd0, 0);

    for (int j = 0; j < NT; j++) write_coef(j, 16'sh7FFF);
    for (int i = 0; i < NT; i++) send("satp", 16'sd32767, 0);
    for (int i = 0; i < NT; i++) send("satn", -16'sd32768, 0);

    send("bp", 16'sd1234, 5);

    in_valid  = 1'b1;
    in_sample = 16'sd2000;
    step();
    in_valid = 1'b0;
    for (int j = NT - 1; j > 0; j--) m_win[j] = m_win[j-1];
    m_win[0] = 16'sd2000;
    exp = model_y();
    coef_we   = 1'b1;
    coef_addr = 2'd2;
    coef_data = 16'sh1234;
    cnt = 0;
    bad = 0;
    while (!out_valid && cnt < 20) begin
      if (coef_ready) bad++;
      step();
      cnt++;
    end
    chk("cw_ready_low_in_mac", bad, 0);
    chk("cw_latency", cnt, NT);
    chk("cw_ready_done", longint'(coef_ready), 1);
    chk("cw_old_coefs", longint'(out_sample), exp);
    step();
    coef_we = 1'b0;
    m_coef[2] = 16'sh1234;
    send("cw_new_coefs", -16'sd700, 0);

    in_valid  = 1'b1;
    in_sample = 16'sd555;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("rmac_in_ready", longint'(in_ready), 1);
    chk("rmac_out_valid", longint'(out_valid), 0);
    chk("rmac_busy", longint'(busy), 0);
    send("rmac_zero", 16'sd1000, 0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = $urandom_range(0, NT - 1);
        write_coef(a, 16'($urandom));
      end
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, NT - 1);
        coef_we   = 1'b1;
        coef_addr = a[$clog2(NT)-1:0];
        coef_data = 16'($urandom);
        m_coef[a] = coef_data;
      end
      case ($urandom_range(0, 4))
        0:       send("rnd", 16'sh7FFF, $urandom_range(0, 3));
        1:       send("rnd", 16'sh8000, $urandom_range(0, 3));
        default: send("rnd", 16'($urandom), $urandom_range(0, 3));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
